nvram_upload_ctrl: RTL and testbench

- Reverse-direction companion to the ROM download path. Streams the Williams CMOS high-score RAM (1024×4) out to the HPS over the ioctl upload handshake, so the frontend can save NVRAM.
- Accepts the matching-index ioctl download to restore the RAM.
- Tracks CPU writes (dirty) and requests an autosave when the OSD opens.
- Sits between hps_io and the CMOS RAM second port, inside emu, in the clk_sys domain.

---
 rtl/nvram_upload_ctrl.sv | 164 ++++++++++++++++
 tb/tb_nvram_upload_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload_ctrl.sv
// NVRAM save/restore bridge between the HPS ioctl port and the CMOS RAM.
// Streams CMOS nibbles out on upload, restores on download, tracks dirtiness.
module nvram_upload_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 4,
    parameter int NV_INDEX = 4,
    parameter int RD_LAT   = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [15:0]       ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_upload_req,
    input  logic              osd_status,
    input  logic              cpu_cmos_wr,
    output logic              cpu_pause,
    output logic [ADDR_W-1:0] cmos_addr,
    output logic              cmos_wr,
    output logic [DATA_W-1:0] cmos_wdata,
    input  logic [DATA_W-1:0] cmos_rdata
);

    localparam int          PAD_W   = 8 - DATA_W;
    localparam logic [15:0] NV_IDX  = 16'(NV_INDEX);
    localparam logic [1:0]  RD_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, ARM, READY, RD_WAIT, PRESENT, WR
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_ok_q, wr_ok_d;
    logic [7:0]        din_q, din_d;
    logic              served_q, served_d;
    logic              dirty_q, dirty_d;
    logic              pause_q;
    logic              up_q, dl_q;
    logic              osd_q;
    logic              req_q, req_d;

    logic sel, active, in_range, fall, clr;
    logic unused_dout;

    assign sel      = (ioctl_index == NV_IDX);
    assign active   = sel & (ioctl_upload | ioctl_download);
    assign in_range = (ioctl_addr[24:ADDR_W] == '0);
    assign fall     = pause_q & ~active;
    assign clr      = fall & ((up_q & served_q) | dl_q);
    assign unused_dout = ^ioctl_dout[7:DATA_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_ok_d  = wr_ok_q;
        din_d    = din_q;
        served_d = served_q;
        if (!active) begin
            // Abort: anything in flight is dropped without touching din.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = ARM;
                    cnt_d    = 2'd0;
                    served_d = 1'b0;
                end
                ARM: begin
                    if (cnt_q == 2'd1) state_d = READY;
                    else cnt_d = cnt_q + 2'd1;
                end
                READY: begin
                    if (ioctl_rd) begin
                        addr_d = ioctl_addr[ADDR_W-1:0];
                        cnt_d  = 2'd0;
                        if (in_range) begin
                            state_d = RD_WAIT;
                        end else begin
                            state_d = PRESENT;
                            din_d   = 8'hFF;
                        end
                    end else if (ioctl_wr) begin
                        state_d = WR;
                        addr_d  = ioctl_addr[ADDR_W-1:0];
                        wdata_d = ioctl_dout[DATA_W-1:0];
                        wr_ok_d = in_range;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == RD_LAST) begin
                        state_d = PRESENT;
                        din_d   = {{PAD_W{1'b1}}, cmos_rdata};
                        if (addr_q == {ADDR_W{1'b1}}) served_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                PRESENT: state_d = READY;
                WR:      state_d = READY;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        if (clr) dirty_d = 1'b0;
        if (cpu_cmos_wr & ~pause_q) dirty_d = 1'b1;
        req_d = osd_status & ~osd_q & dirty_q & (state_q == IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_ok_q  <= 1'b0;
            din_q    <= 8'hFF;
            served_q <= 1'b0;
            dirty_q  <= 1'b0;
            pause_q  <= 1'b0;
            up_q     <= 1'b0;
            dl_q     <= 1'b0;
            osd_q    <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_ok_q  <= wr_ok_d;
            din_q    <= din_d;
            served_q <= served_d;
            dirty_q  <= dirty_d;
            pause_q  <= active;
            osd_q    <= osd_status;
            req_q    <= req_d;
            if (active) begin
                up_q <= ioctl_upload;
                dl_q <= ioctl_download;
            end
        end
    end

    assign ioctl_din        = din_q;
    assign ioctl_upload_req = req_q;
    assign cpu_pause        = pause_q;
    // READY presents the live address so the RAM read starts on the strobe edge.
    assign cmos_addr  = (state_q == READY) ? ioctl_addr[ADDR_W-1:0] : addr_q;
    assign cmos_wr    = (state_q == WR) & wr_ok_q & active & ~reset;
    assign cmos_wdata = wdata_q;

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Directed bench for nvram_upload_ctrl with a behavioural 1024x4 CMOS RAM.
module tb_nvram_upload_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_upload, ioctl_rd, ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] ioctl_index;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;
    logic        osd_status, cpu_cmos_wr, cpu_pause;
    logic [9:0]  cmos_addr;
    logic        cmos_wr;
    logic [3:0]  cmos_wdata, cmos_rdata;

    logic [3:0] mem [1024];
    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int req_cnt = 0;

    always #5 clk = ~clk;

    nvram_upload_ctrl dut (
        .clk_sys(clk), .reset(reset),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
        .ioctl_upload_req(ioctl_upload_req), .osd_status(osd_status),
        .cpu_cmos_wr(cpu_cmos_wr), .cpu_pause(cpu_pause),
        .cmos_addr(cmos_addr), .cmos_wr(cmos_wr),
        .cmos_wdata(cmos_wdata), .cmos_rdata(cmos_rdata)
    );

    always @(posedge clk) begin
        cmos_rdata <= mem[cmos_addr];
        if (cmos_wr) begin
            mem[cmos_addr] <= cmos_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (ioctl_upload_req) req_cnt <= req_cnt + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [24:0] a, input logic [7:0] exp);
        ioctl_addr = a;
        ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        chk($sformatf("rd_%0d", a), 32'(ioctl_din), 32'(exp));
        tick(3);
    endtask

    task automatic do_write(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 4'(i);
        reset = 1'b1;
        ioctl_upload = 1'b0; ioctl_rd = 1'b0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = 16'd0;
        osd_status = 1'b0; cpu_cmos_wr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick();
        chk("rst_din", 32'(ioctl_din), 32'hFF);
        chk("rst_pause", 32'(cpu_pause), 0);
        chk("rst_req", 32'(ioctl_upload_req), 0);
        chk("rst_wr", 32'(cmos_wr), 0);
        chk("rst_addr", 32'(cmos_addr), 0);
        chk("rst_wdata", 32'(cmos_wdata), 0);

        // dirty + autosave request
        cpu_cmos_wr = 1'b1;
        tick();
        cpu_cmos_wr = 1'b0;
        osd_status = 1'b1;
        tick();
        chk("req_pulse", 32'(ioctl_upload_req), 1);
        tick();
        chk("req_end", 32'(ioctl_upload_req), 0);
        tick(3);
        chk("req_once", 32'(req_cnt), 1);
        osd_status = 1'b0;
        tick();

        // wrong index download is invisible
        ioctl_index = 16'd0;
        ioctl_download = 1'b1;
        tick(4);
        do_write(25'd5, 8'h3A);
        tick(3);
        chk("wi_pause", 32'(cpu_pause), 0);
        chk("wi_wrcnt", 32'(wr_cnt), 0);
        chk("wi_din", 32'(ioctl_din), 32'hFF);
        chk("wi_mem5", 32'(mem[5]), 5);
        ioctl_download = 1'b0;
        tick();

        // upload walk
        ioctl_index = 16'd4;
        ioctl_upload = 1'b1;
        tick();
        chk("up_pause", 32'(cpu_pause), 1);
        tick(3);
        do_read(25'd0, 8'hF0);
        do_read(25'd1024, 8'hFF);
        for (int n = 0; n < 1024; n++) do_read(25'(n), 8'hF0 | 8'(n & 15));
        chk("up_wrcnt", 32'(wr_cnt), 0);
        ioctl_upload = 1'b0;
        tick();
        chk("up_unpause", 32'(cpu_pause), 0);
        osd_status = 1'b1;
        tick(3);
        chk("up_clean", 32'(req_cnt), 1);
        osd_status = 1'b0;
        tick();

        // download restore, dirty cleared at end
        cpu_cmos_wr = 1'b1;
        tick();
        cpu_cmos_wr = 1'b0;
        ioctl_download = 1'b1;
        tick();
        chk("dl_pause", 32'(cpu_pause), 1);
        tick(3);
        cpu_cmos_wr = 1'b1;
        tick();
        cpu_cmos_wr = 1'b0;
        do_write(25'd5, 8'h3A);
        chk("dl_wr", 32'(cmos_wr), 1);
        chk("dl_addr", 32'(cmos_addr), 5);
        chk("dl_wdata", 32'(cmos_wdata), 32'hA);
        tick();
        chk("dl_wr_end", 32'(cmos_wr), 0);
        chk("dl_mem5", 32'(mem[5]), 32'hA);
        chk("dl_wrcnt", 32'(wr_cnt), 1);
        tick(3);
        do_write(25'd2000, 8'hFF);
        tick(3);
        chk("dl_oor_cnt", 32'(wr_cnt), 1);
        chk("dl_oor_mem", 32'(mem[976]), 0);
        ioctl_download = 1'b0;
        tick();
        chk("dl_unpause", 32'(cpu_pause), 0);
        osd_status = 1'b1;
        tick(3);
        chk("dl_clean", 32'(req_cnt), 1);
        osd_status = 1'b0;
        tick();

        // abort mid-read keeps dirty and din
        cpu_cmos_wr = 1'b1;
        tick();
        cpu_cmos_wr = 1'b0;
        ioctl_upload = 1'b1;
        tick(4);
        ioctl_addr = 25'd7;
        ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        ioctl_upload = 1'b0;
        tick();
        chk("ab_pause", 32'(cpu_pause), 0);
        chk("ab_din", 32'(ioctl_din), 32'hFF);
        tick(2);
        osd_status = 1'b1;
        tick(3);
        chk("ab_dirty", 32'(req_cnt), 2);
        osd_status = 1'b0;
        tick();

        // reset during WR
        ioctl_download = 1'b1;
        tick(4);
        do_write(25'd9, 8'h55);
        chk("rw_wr", 32'(cmos_wr), 1);
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick();
        chk("rw_wr_off", 32'(cmos_wr), 0);
        chk("rw_pause", 32'(cpu_pause), 0);
        chk("rw_din", 32'(ioctl_din), 32'hFF);
        chk("rw_addr", 32'(cmos_addr), 0);
        chk("rw_wdata", 32'(cmos_wdata), 0);
        chk("rw_mem9", 32'(mem[9]), 9);
        chk("rw_wrcnt", 32'(wr_cnt), 1);
        reset = 1'b0;
        tick();
        osd_status = 1'b1;
        tick(3);
        chk("rw_clean", 32'(req_cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
